// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Front-end driver for the 32-bit MIPS ALU. It accepts decoded ALU requests
// over a valid/ready handshake, translates ALUOp/funct into the ALU's 3-bit
// operation code, and drives registered operands into the ALU. The ALU
// registers its result one edge later, and this block captures it one edge
// after that. The result, zero flag, branch-taken flag, error flag and echoed
// tag are then returned over a valid/ready response port.
//
// Ports
//   clk, rst          rising-edge clock (shared with the ALU), sync active-high reset
//   req_valid/ready   request handshake
//   req_aluop[1:0]    00 add, 01 sub (branch), 10 R-type via funct, 11 illegal
//   req_funct[5:0]    R-type funct field
//   req_a, req_b      32-bit operands
//   req_tag[4:0]      destination register, echoed on the response
//   req_bne           branch sense (1 = bne), meaningful only for aluop 01
//   alu_a, alu_b      registered operands to the ALU
//   alu_operation     registered 3-bit ALU operation code
//   alu_result        ALU result (registered inside the ALU)
//   alu_zero          ALU zero flag
//   rsp_valid/ready   response handshake
//   rsp_result        captured ALU result (0 for an illegal op)
//   rsp_zero          captured zero flag
//   rsp_taken         branch decision
//   rsp_err           illegal operation
//   rsp_tag           echoed tag
//   op_count[15:0]    completed responses, wraps modulo 2^16
//
// Timing: a legal request accepted at edge T produces rsp_valid after T+2,
// which is 3 cycles of latency. An illegal request produces rsp_valid after T,
// which is 1 cycle of latency. While in RESP the request port is ready exactly
// when the consumer is ready. This allows a new op to be accepted on the same
// edge that retires the current response.
// -----------------------------------------------------------------------------
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_aluop,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_tag,
  input  logic        req_bne,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_operation,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_taken,
  output logic        rsp_err,
  output logic [4:0]  rsp_tag,
  output logic [15:0] op_count
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Returns {illegal, op}. Illegal encodings return op = 000, which is never
  // used because illegal requests do not touch the ALU registers.
  function automatic logic [3:0] decode_op(input logic [1:0] aluop,
                                           input logic [5:0] funct);
    logic [3:0] r;
    r = {1'b1, 3'b000};
    case (aluop)
      2'b00: r = {1'b0, OP_ADD};
      2'b01: r = {1'b0, OP_SUB};
      2'b10: begin
        case (funct)
          6'h20:   r = {1'b0, OP_ADD};
          6'h22:   r = {1'b0, OP_SUB};
          6'h24:   r = {1'b0, OP_AND};
          6'h25:   r = {1'b0, OP_OR};
          6'h2A:   r = {1'b0, OP_SLT};
          default: r = {1'b1, 3'b000};
        endcase
      end
      default: r = {1'b1, 3'b000};
    endcase
    return r;
  endfunction

  logic [3:0] dec;
  logic       dec_illegal;
  logic [2:0] dec_op;
  logic       accept;
  logic       rsp_fire;

  assign dec         = decode_op(req_aluop, req_funct);
  assign dec_illegal = dec[3];
  assign dec_op      = dec[2:0];
  assign accept      = req_valid & req_ready;
  assign rsp_fire    = rsp_valid & rsp_ready;

  // Request fields needed at capture time, held from accept to CAPT.
  logic [1:0] aluop_p0;
  logic       bne_p0;
  logic [4:0] tag_p0;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = dec_illegal ? RESP : EXEC;
        end
      end
      EXEC: state_nxt = CAPT;
      CAPT: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (accept) begin
            state_nxt = dec_illegal ? RESP : EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
      end
      default: begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage p0: accept, load ALU operands/operation, hold branch info and tag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_operation <= 3'b000;
    end else if (accept && !dec_illegal) begin
      alu_a         <= req_a;
      alu_b         <= req_b;
      alu_operation <= dec_op;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      aluop_p0 <= req_aluop;
      bne_p0   <= req_bne;
      tag_p0   <= req_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: capture the ALU result (CAPT), or build the error response
  // directly at accept. An accept from RESP only happens on the retiring
  // handshake, so overwriting the response fields here never breaks the
  // hold-while-stalled rule.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_taken  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_tag    <= '0;
    end else if (accept && dec_illegal) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_taken  <= 1'b0;
      rsp_err    <= 1'b1;
      rsp_tag    <= req_tag;
    end else if (state == CAPT) begin
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      // Equal operands give zero = 1: beq takes on zero, bne on non-zero.
      rsp_taken  <= (aluop_p0 == 2'b01) & (alu_zero ^ bne_p0);
      rsp_err    <= 1'b0;
      rsp_tag    <= tag_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (rsp_fire) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_aluop;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_tag;
  logic        req_bne;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_operation;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_taken;
  logic        rsp_err;
  logic [4:0]  rsp_tag;
  logic [15:0] op_count;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .req_bne(req_bne),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_taken(rsp_taken),
    .rsp_err(rsp_err), .rsp_tag(rsp_tag), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple ALU with a registered result stage.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [31:0] d;
    d = a - b;
    case (op)
      3'b010:  return a + b;
      3'b110:  return d;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return {31'b0, d[31]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_result <= alu_fn(alu_a, alu_b, alu_operation);
    alu_zero   <= (alu_fn(alu_a, alu_b, alu_operation) == 32'h0);
  end

  // Reference model: expected response of one request.
  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        taken;
    logic        err;
    logic [4:0]  tag;
    logic [31:0] acc;
  } rsp_t;

  function automatic logic legal(input logic [1:0] aluop, input logic [5:0] funct);
    if (aluop == 2'b00 || aluop == 2'b01) return 1'b1;
    if (aluop == 2'b11) return 1'b0;
    return (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
            funct == 6'h25 || funct == 6'h2A);
  endfunction

  function automatic logic [2:0] ref_op(input logic [1:0] aluop, input logic [5:0] funct);
    if (aluop == 2'b00) return 3'b010;
    if (aluop == 2'b01) return 3'b110;
    case (funct)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  function automatic rsp_t ref_rsp(input logic [1:0] aluop, input logic [5:0] funct,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] tag, input logic bne,
                                   input logic [31:0] acc);
    rsp_t r;
    logic signed [31:0] diff;
    diff = a - b;
    r.tag = tag;
    r.acc = acc;
    r.err = !legal(aluop, funct);
    r.result = 32'h0;
    if (!r.err) begin
      if (aluop == 2'b00) r.result = a + b;
      else if (aluop == 2'b01) r.result = a - b;
      else begin
        case (funct)
          6'h20:   r.result = a + b;
          6'h22:   r.result = a - b;
          6'h24:   r.result = a & b;
          6'h25:   r.result = a | b;
          default: r.result = (diff < 0) ? 32'd1 : 32'd0;
        endcase
      end
    end
    r.zero  = !r.err && (r.result == 32'h0);
    r.taken = (aluop == 2'b01) && (bne ? (a != b) : (a == b));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard and monitor.
  rsp_t        q[$];
  rsp_t        mon_e;
  logic        mon_en  = 1'b0;
  logic        new_rsp = 1'b1;
  logic [15:0] exp_cnt = 16'h0;
  logic [31:0] exp_a   = 32'h0;
  logic [31:0] exp_b   = 32'h0;
  logic [2:0]  exp_op  = 3'b000;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("op_count", {16'h0, op_count}, {16'h0, exp_cnt});
      chk("alu_a", alu_a, exp_a);
      chk("alu_b", alu_b, exp_b);
      chk("alu_operation", {29'h0, alu_operation}, {29'h0, exp_op});
      if (rsp_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with no outstanding request (cycle %0d)", cyc);
        end else begin
          mon_e = q[0];
          if (new_rsp)
            chk("latency", cyc - mon_e.acc, mon_e.err ? 32'd1 : 32'd3);
          chk("rsp_result", rsp_result, mon_e.result);
          chk("rsp_zero", {31'h0, rsp_zero}, {31'h0, mon_e.zero});
          chk("rsp_taken", {31'h0, rsp_taken}, {31'h0, mon_e.taken});
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e.err});
          chk("rsp_tag", {27'h0, rsp_tag}, {27'h0, mon_e.tag});
        end
        chk("req_ready_in_resp", {31'h0, req_ready}, {31'h0, rsp_ready});
        new_rsp = rsp_ready;
      end else begin
        new_rsp = 1'b1;
      end
      if (rst) begin
        q.delete();
        exp_cnt = 16'h0;
        exp_a   = 32'h0;
        exp_b   = 32'h0;
        exp_op  = 3'b000;
        new_rsp = 1'b1;
      end else begin
        if (rsp_valid && rsp_ready && q.size() > 0) begin
          void'(q.pop_front());
          exp_cnt = exp_cnt + 16'd1;
        end
        if (req_valid && req_ready) begin
          q.push_back(ref_rsp(req_aluop, req_funct, req_a, req_b, req_tag, req_bne, cyc));
          if (legal(req_aluop, req_funct)) begin
            exp_a  = req_a;
            exp_b  = req_b;
            exp_op = ref_op(req_aluop, req_funct);
          end
        end
      end
    end
  end

  // Stimulus.
  logic rnd_mode = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Leaves req_valid high so consecutive calls issue back to back.
  task automatic send(input logic [1:0] aluop, input logic [5:0] funct,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic bne);
    logic acc;
    acc = 1'b0;
    req_aluop = aluop;
    req_funct = funct;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    req_bne   = bne;
    req_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
        break;
      end
      tick();
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req_ready=0 expected 1 within 60 cycles");
    end
    tick();
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rnd_mode  = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0 && !rsp_valid) break;
      tick();
    end
    chk("drain_outstanding", q.size(), 32'd0);
  endtask

  logic [5:0] fl[0:4] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  initial begin
    logic [1:0]  ra;
    logic [5:0]  rf;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_aluop = 2'b00; req_funct = 6'h0; req_a = 32'h0; req_b = 32'h0;
    req_tag = 5'h0; req_bne = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("reset_req_ready", {31'h0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("reset_op_count", {16'h0, op_count}, 32'd0);
    chk("reset_alu_a", alu_a, 32'h0);
    chk("reset_alu_op", {29'h0, alu_operation}, 32'h0);
    chk("reset_rsp_result", rsp_result, 32'h0);
    chk("reset_rsp_tag", {27'h0, rsp_tag}, 32'h0);
    mon_en = 1'b1;
    tick();

    // Directed operations from the plan.
    send(2'b10, 6'h20, 32'h7FFFFFFF, 32'h1, 5'd9, 1'b0);
    req_valid = 1'b0; repeat (4) tick();
    send(2'b01, 6'h00, 32'h1234, 32'h1234, 5'd3, 1'b0);
    send(2'b01, 6'h00, 32'h1234, 32'h1234, 5'd4, 1'b1);
    send(2'b01, 6'h00, 32'h1234, 32'h1235, 5'd5, 1'b1);
    send(2'b10, 6'h2A, 32'hFFFFFFFF, 32'h1, 5'd6, 1'b0);
    send(2'b10, 6'h2A, 32'h1, 32'hFFFFFFFF, 5'd7, 1'b0);
    send(2'b10, 6'h27, 32'hDEAD, 32'hBEEF, 5'd8, 1'b0);
    send(2'b11, 6'h20, 32'h5, 32'h6, 5'd10, 1'b0);
    send(2'b10, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 5'd11, 1'b0);
    send(2'b10, 6'h25, 32'hF0F0F0F0, 32'h0F0F0000, 5'd12, 1'b0);
    send(2'b00, 6'h3F, 32'hFFFFFFFF, 32'h2, 5'd13, 1'b1);
    drain();

    // Response held for 5 cycles with the consumer stalled.
    rsp_ready = 1'b0;
    send(2'b10, 6'h22, 32'h10, 32'h30, 5'd14, 1'b0);
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !rsp_valid; i++) tick();
    chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'd1);
    repeat (5) tick();
    rsp_ready = 1'b1;
    drain();

    // Reset in the cycle after a legal accept abandons the op.
    send(2'b00, 6'h00, 32'h11, 32'h22, 5'd15, 1'b0);
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      tick();
    end
    chk("post_reset_op_count", {16'h0, op_count}, 32'd0);
    chk("post_reset_alu_a", alu_a, 32'h0);
    chk("post_reset_rsp_tag", {27'h0, rsp_tag}, 32'h0);

    // Randomized traffic with random consumer backpressure.
    rnd_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      ra = (sel < 2) ? 2'b00 : (sel < 4) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      rf = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : fl[$urandom_range(0, 4)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 4) == 0) begin
        a = 32'($urandom_range(0, 3)) - 32'd1;
        b = 32'($urandom_range(0, 3)) - 32'd1;
      end
      send(ra, rf, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
      end
    end
    drain();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
